// File: rtl/execute_mc_pkg.sv
// Shared types and constants for the execute stage and its multiplier.
package execute_mc_pkg;

  // Operation codes carried on in_op.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_ANDN = 4'd3,
    OP_ROL  = 4'd4,
    OP_SLL  = 4'd5,
    OP_ROR  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SEQ  = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLE  = 4'd10,
    OP_SCO  = 4'd11,
    OP_BTR  = 4'd12,
    OP_LBI  = 4'd13,
    OP_SLBI = 4'd14,
    OP_MUL  = 4'd15
  } op_e;

  // Multiplier sequencing state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Op-code groups selected by in_op[3:2].
  localparam logic [1:0] GRP_CMP     = 2'b10;
  localparam logic [1:0] GRP_SPECIAL = 2'b11;

  // Compare ops produce a single bit, zero-extended to the datapath width.
  function automatic logic is_cmp(input logic [3:0] op);
    return op[3:2] == GRP_CMP;
  endfunction

  // BTR/LBI/SLBI; MUL shares the group but is iterative.
  function automatic logic is_special(input logic [3:0] op);
    return (op[3:2] == GRP_SPECIAL) && (op != 4'(OP_MUL));
  endfunction

endpackage

// File: rtl/execute_mc_if.sv
// Operand/result handshake bundle between decode, execute and memory.
interface execute_mc_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_imm;
  logic             in_src_imm;
  logic [3:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_ofl;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, in_a, in_b, in_imm, in_src_imm, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_ofl
  );

  // Execute stage side.
  modport slave (
    input  in_valid, in_a, in_b, in_imm, in_src_imm, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_ofl
  );
endinterface

// File: rtl/execute_mc_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
module mul_iter
  import execute_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_c_o,
  output logic [WIDTH-1:0] result_c_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_c;
  logic [WIDTH-1:0] acc_next_c;

  assign last_c     = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_next_c = acc_q + (mplier_q[0] ? mcand_q : '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort wins over everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_BUSY;
      ST_BUSY: if (last_c)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort_i) state_d = ST_IDLE;
  end

  // Outputs: done marks the edge on which the final sum is available.
  always_comb begin
    busy_o     = 1'b0;
    done_c_o   = 1'b0;
    result_c_o = acc_next_c;
    if (state_q == ST_BUSY) begin
      busy_o   = 1'b1;
      done_c_o = last_c;
    end
  end

  // Datapath next values.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (abort_i) begin
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      cnt_d    = '0;
    end else if (state_q == ST_IDLE && start_i) begin
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
      cnt_d    = '0;
    end else if (state_q == ST_BUSY) begin
      acc_d    = acc_next_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/execute_mc.sv
// Handshaked execute stage: single-cycle ALU/compare/special ops plus iterative MUL.
module execute_mc
  import execute_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  execute_mc_if.slave  bus
);

  localparam int unsigned SH_W = $clog2(WIDTH);
  localparam int unsigned H    = WIDTH / 2;

  logic [WIDTH-1:0]   a, b, sum, diff_ba, diff_ab, btr;
  logic [2*WIDTH-1:0] rol_w, ror_w;
  logic [SH_W-1:0]    shamt;
  logic               carry, eq, lt;
  logic [3:0]         op;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ofl, cmp_bit;

  logic               in_ready_c, accept, mul_start, alu_load, mul_load;
  logic               mul_busy, mul_done;
  logic [WIDTH-1:0]   mul_res;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_zero_q, out_zero_d;
  logic               out_ofl_q, out_ofl_d;

  assign a        = bus.in_a;
  assign b        = bus.in_src_imm ? bus.in_imm : bus.in_b;
  assign op       = bus.in_op;
  assign shamt    = b[SH_W-1:0];
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
  assign diff_ba  = b - a;
  assign diff_ab  = a - b;
  assign rol_w    = {a, a} << shamt;
  assign ror_w    = {a, a} >> shamt;
  assign eq       = (a == b);
  // N xor V of A-B keeps signed less-than correct across overflow.
  assign lt       = diff_ab[WIDTH-1] ^
                    ((a[WIDTH-1] ^ b[WIDTH-1]) & (diff_ab[WIDTH-1] ^ a[WIDTH-1]));

  // Bit reversal of operand A.
  always_comb begin
    btr = '0;
    for (int i = 0; i < int'(WIDTH); i++) btr[i] = a[int'(WIDTH) - 1 - i];
  end

  // Single-cycle result mux.
  always_comb begin
    alu_res = '0;
    alu_ofl = 1'b0;
    cmp_bit = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        alu_res = sum;
        alu_ofl = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ba;
        alu_ofl = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ba[WIDTH-1] != b[WIDTH-1]);
      end
      OP_XOR:  alu_res = a ^ b;
      OP_ANDN: alu_res = a & ~b;
      OP_ROL:  alu_res = rol_w[2*WIDTH-1:WIDTH];
      OP_SLL:  alu_res = a << shamt;
      OP_ROR:  alu_res = ror_w[WIDTH-1:0];
      OP_SRL:  alu_res = a >> shamt;
      OP_SEQ:  cmp_bit = eq;
      OP_SLT:  cmp_bit = lt;
      OP_SLE:  cmp_bit = lt | eq;
      OP_SCO:  cmp_bit = carry;
      OP_BTR:  alu_res = btr;
      OP_LBI:  alu_res = bus.in_imm;
      OP_SLBI: alu_res = {a[H-1:0], bus.in_imm[H-1:0]};
      default: alu_res = '0;
    endcase
    if (is_cmp(op)) alu_res = WIDTH'(cmp_bit);
  end

  // Handshake: accept only when idle, not flushing and the output slot frees up.
  assign in_ready_c   = ~mul_busy & ~flush & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & in_ready_c;
  assign mul_start    = accept & (op == 4'(OP_MUL));
  assign alu_load     = accept & (op != 4'(OP_MUL));
  assign mul_load     = mul_done & ~flush;
  assign bus.in_ready = in_ready_c;

  mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .start_i    (mul_start),
    .abort_i    (flush),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (mul_busy),
    .done_c_o   (mul_done),
    .result_c_o (mul_res)
  );

  // Output register next values; flush outranks loads and drains.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    out_ofl_d   = out_ofl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (alu_load) begin
      out_valid_d = 1'b1;
      out_data_d  = alu_res;
      out_zero_d  = (alu_res == '0);
      out_ofl_d   = alu_ofl;
    end else if (mul_load) begin
      out_valid_d = 1'b1;
      out_data_d  = mul_res;
      out_zero_d  = (mul_res == '0);
      out_ofl_d   = 1'b0;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_ofl_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_ofl_q   <= out_ofl_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ofl   = out_ofl_q;

endmodule
